logic_unit_arbiter: RTL and testbench
=====================================

// Module: logic_unit_arbiter
// PURPOSE
//  Shares one 16-bit bitwise logic unit (AND/OR/XOR/NOT) among NUM_REQ requesters.
//  Each requester offers a request over a valid/ready handshake, and a round-robin
//  arbiter grants one request at a time. The block computes the result, registers it,
//  and returns it with the winning requester's ID over a valid/ready response port.
//  It sits between multiple project datapaths and the single shared gate-level unit.
// PARAMETERS
//  WIDTH    16  operand/result width in bits
//  NUM_REQ  4   number of requesters (2..8); ID_W = $clog2(NUM_REQ)
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              synchronous, active-high reset
//  req_valid  in   NUM_REQ        per-requester request valid
//  req_ready  out  NUM_REQ        per-requester accept; at most one bit high
//  req_a      in   NUM_REQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NUM_REQ*WIDTH  operand B, same packing
//  req_op     in   NUM_REQ*2      op code; 00 AND, 01 OR, 10 XOR, 11 NOT a (b ignored)
//  resp_valid out  1              result valid
//  resp_ready in   1              consumer accepts result
//  resp_data  out  WIDTH          result
//  resp_id    out  ID_W           index of the requester that owns resp_data
//  busy       out  1              high whenever state != IDLE
// BEHAVIOUR
//  - Reset (sampled at clk edge): state=IDLE, rr_ptr=0, resp_valid=0, resp_data=0,
//    resp_id=0, busy=0, req_ready=0. Reset overrides all other inputs in that cycle.
//  - FSM states: IDLE -> COMPUTE -> RESPOND -> IDLE.
//    IDLE: if any req_valid, winner = first valid index at or after rr_ptr, searching
//      upward with wrap-around. req_ready[winner]=1 combinationally this cycle, all other
//      bits 0. At the edge, latch a/b/op/id of the winner, set rr_ptr=(winner+1)%NUM_REQ,
//      and go to COMPUTE. If no request is valid, stay in IDLE; rr_ptr is unchanged.
//    COMPUTE: req_ready=0. At the edge, register resp_data=op(a,b) and resp_id, then go
//      to RESPOND.
//    RESPOND: resp_valid=1; resp_data and resp_id are held stable. Return to IDLE on the
//      edge where resp_ready=1. Otherwise hold indefinitely; req_ready stays 0.
//  - req_ready is 0 in COMPUTE, in RESPOND, and during reset. No new request is
//    accepted until the response has been consumed.
//  - Latency: accept in cycle C, resp_valid high from cycle C+2. With resp_ready tied
//    high, the next accept occurs in C+3, so peak throughput is 1 request per 3 cycles.
//  - resp_valid is low in IDLE and COMPUTE. resp_data and resp_id keep their last value
//    outside RESPOND; they are not cleared.
//  - A requester must hold valid/a/b/op stable until it sees ready. Dropping valid
//    before ready is allowed; the request is then simply not granted.
//  - Simultaneous requests are resolved by the round-robin pointer only.
//    Starvation-free: a requester held valid is granted within NUM_REQ grants.
//  - NOT ignores req_b entirely; all ops are pure bitwise, with no carry or width change.
//  - Reset mid-operation (COMPUTE or RESPOND) discards the in-flight request. The
//    next cycle shows resp_valid=0 and state=IDLE, and no response is ever produced.
// TESTING
//  1. req0 OR a=0x1234 b=0x9876, resp_ready=1 -> req_ready[0] high 1 cycle;
//     2 cycles later resp_valid=1, resp_data=0x9A76, resp_id=0.
//  2. Ops on req2: AND 0xAAAA,0x5555 -> 0x0000; XOR 0x3CC3,0x0FF0 -> 0x3333;
//     NOT a=0x0000 b=0x1234 -> 0xFFFF; each with resp_id=2.
//  3. All 4 req_valid held high from reset, resp_ready=1 -> grant order 0,1,2,3,0;
//     each grant is exactly 3 cycles apart.
//  4. Backpressure: resp_ready=0 for 5 cycles in RESPOND -> resp_valid, resp_data and
//     resp_id stay stable, req_ready=0 throughout; resp_ready=1 -> IDLE next cycle.
//  5. Pointer wrap: rr_ptr=3 (after grant to 2); req1 and req3 valid -> 3 granted
//     first, then 1.
//  6. reset=1 for one cycle while in COMPUTE -> next cycle resp_valid=0, busy=0;
//     a req1 request then gets granted (rr_ptr=0 search) with correct data.

Source files
------------

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for the shared logic unit. The arbiter takes the slave side
// and the requesters plus the result consumer take the master side.
interface logic_unit_arbiter_if #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ*2-1:0]     req_op;
   logic                     resp_valid;
   logic                     resp_ready;
   logic [WIDTH-1:0]         resp_data;
   logic [ID_W-1:0]          resp_id;

   modport slave (
      input  req_valid, req_a, req_b, req_op, resp_ready,
      output req_ready, resp_valid, resp_data, resp_id
   );

   modport master (
      output req_valid, req_a, req_b, req_op, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_id
   );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin shared 16-bit bitwise logic unit: grant one requester, compute the op,
// then hold the registered result until the consumer takes it.
module logic_unit_arbiter #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   logic_unit_arbiter_if.slave  bus,
   output logic                 busy
);
   localparam int unsigned ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {StIdle, StCompute, StRespond} state_e;

   state_e           state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [ID_W-1:0]  resp_id_q, resp_id_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] resp_data_q, resp_data_d;
   logic [1:0]       op_q, op_d;
   logic [ID_W-1:0]  winner;
   logic [ID_W-1:0]  cand;
   logic             found;
   logic [WIDTH-1:0] result;

   // First valid index at or after rr_ptr, wrapping around.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!found && bus.req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      unique case (op_q)
         2'b00:   result = a_q & b_q;
         2'b01:   result = a_q | b_q;
         2'b10:   result = a_q ^ b_q;
         default: result = ~a_q;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      id_d          = id_q;
      a_d           = a_q;
      b_d           = b_q;
      op_d          = op_q;
      resp_data_d   = resp_data_q;
      resp_id_d     = resp_id_q;
      bus.req_ready = '0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               bus.req_ready[winner] = !reset;
               a_d      = bus.req_a[32'(winner)*WIDTH +: WIDTH];
               b_d      = bus.req_b[32'(winner)*WIDTH +: WIDTH];
               op_d     = bus.req_op[32'(winner)*2 +: 2];
               id_d     = winner;
               rr_ptr_d = (32'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
               state_d  = StCompute;
            end
         end
         StCompute: begin
            resp_data_d = result;
            resp_id_d   = id_q;
            state_d     = StRespond;
         end
         StRespond: begin
            if (bus.resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         resp_data_q <= '0;
         resp_id_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         resp_data_q <= resp_data_d;
         resp_id_q   <= resp_id_d;
      end
   end

   assign bus.resp_valid = (state_q == StRespond);
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_id    = resp_id_q;
   assign busy           = (state_q != StIdle);
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: expected responses are queued as requests are
// issued and checked as the DUT hands them back; grants are logged for order/spacing.
module tb_logic_unit_arbiter;
   localparam int unsigned WIDTH   = 16;
   localparam int unsigned NUM_REQ = 4;

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic busy;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sb[$];
   int   grant_q[$];
   int   grant_cyc_q[$];

   logic_unit_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

   logic_unit_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Grant log and response scoreboard.
   always @(negedge clk) begin
      check("ready_onehot0", 32'($onehot0(bus.req_ready)), 1);
      if (|bus.req_ready) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready[i]) begin
               grant_q.push_back(i);
               grant_cyc_q.push_back(cyc);
            end
         end
      end
      if (!reset && bus.resp_valid && bus.resp_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL resp_unexpected observed=%h expected=none", bus.resp_data);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("resp_data", 32'(bus.resp_data), 32'(e.data));
            check("resp_id", 32'(bus.resp_id), 32'(e.id));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b);
      bus.req_a[i*WIDTH +: WIDTH] = a;
      bus.req_b[i*WIDTH +: WIDTH] = b;
      bus.req_op[i*2 +: 2]        = op;
      bus.req_valid[i]            = 1'b1;
   endtask

   // Single requester from IDLE with resp_ready high: grant now, response two cycles on.
   task automatic do_req(input int i, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp);
      int n = 0;
      set_req(i, op, a, b);
      sb.push_back('{id: 2'(i), data: exp});
      @(negedge clk);
      while (!bus.req_ready[i] && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("grant_seen", 32'(bus.req_ready[i]), 1);
      check("grant_wait", 32'(n), 0);
      tick();
      bus.req_valid[i] = 1'b0;
      @(negedge clk);
      check("compute_resp_valid", 32'(bus.resp_valid), 0);
      check("compute_busy", 32'(busy), 1);
      check("compute_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
      check("respond_valid", 32'(bus.resp_valid), 1);
      tick();
   endtask

   task automatic wait_grants(input int n);
      int t = 0;
      while (grant_q.size() < n && t < 40) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("grant_count", 32'(grant_q.size()), 32'(n));
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb.size() != 0 && t < 40) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("sb_drained", 32'(sb.size()), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset          = 1'b1;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_op     = '0;
      bus.resp_ready = 1'b1;
      tick();
      @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 0);
      check("rst_resp_valid", 32'(bus.resp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_resp_data", 32'(bus.resp_data), 0);
      check("rst_resp_id", 32'(bus.resp_id), 0);
      check("idle_busy", 32'(busy), 0);
      tick();

      // Basic OR on requester 0, then all ops on requester 2.
      do_req(0, 2'b01, 16'h1234, 16'h9876, 16'h9A76);
      do_req(2, 2'b00, 16'hAAAA, 16'h5555, 16'h0000);
      do_req(2, 2'b10, 16'h3CC3, 16'h0FF0, 16'h3333);
      do_req(2, 2'b11, 16'h0000, 16'h1234, 16'hFFFF);
      wait_drain();

      // All four held valid from reset: grants 0,1,2,3,0 three cycles apart.
      tick();
      reset = 1'b1;
      set_req(0, 2'b00, 16'h0F0F, 16'h00FF);
      set_req(1, 2'b01, 16'h1200, 16'h0034);
      set_req(2, 2'b10, 16'hFFFF, 16'h1234);
      set_req(3, 2'b11, 16'h8001, 16'hFFFF);
      @(negedge clk);
      check("ready_in_reset", 32'(bus.req_ready), 0);
      tick();
      reset = 1'b0;
      grant_q.delete();
      grant_cyc_q.delete();
      sb.push_back('{id: 2'd0, data: 16'h000F});
      sb.push_back('{id: 2'd1, data: 16'h1234});
      sb.push_back('{id: 2'd2, data: 16'hEDCB});
      sb.push_back('{id: 2'd3, data: 16'h7FFE});
      sb.push_back('{id: 2'd0, data: 16'h000F});
      wait_grants(5);
      tick();
      bus.req_valid = '0;
      if (grant_q.size() >= 5) begin
         for (int k = 0; k < 5; k++) check("rr_order", 32'(grant_q[k]), 32'(k % 4));
         for (int k = 0; k < 4; k++)
            check("grant_spacing", 32'(grant_cyc_q[k+1] - grant_cyc_q[k]), 3);
      end
      wait_drain();
      tick();

      // Backpressure on requester 1 (rr_ptr=1 here).
      bus.resp_ready = 1'b0;
      set_req(1, 2'b00, 16'hF0F0, 16'hFF00);
      sb.push_back('{id: 2'd1, data: 16'hF000});
      @(negedge clk);
      check("bp_grant", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid = '0;
      tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_valid", 32'(bus.resp_valid), 1);
         check("bp_data", 32'(bus.resp_data), 32'hF000);
         check("bp_id", 32'(bus.resp_id), 1);
         check("bp_ready", 32'(bus.req_ready), 0);
         tick();
      end
      bus.resp_ready = 1'b1;
      tick();
      @(negedge clk);
      check("bp_release_valid", 32'(bus.resp_valid), 0);
      check("bp_release_busy", 32'(busy), 0);
      tick();

      // Pointer wrap: grant 2 so rr_ptr=3, then 1 and 3 together -> 3 first, then 1.
      do_req(2, 2'b10, 16'h00FF, 16'h0F0F, 16'h0FF0);
      grant_q.delete();
      grant_cyc_q.delete();
      set_req(1, 2'b01, 16'h0001, 16'h0002);
      set_req(3, 2'b11, 16'h00FF, 16'h1234);
      sb.push_back('{id: 2'd3, data: 16'hFF00});
      sb.push_back('{id: 2'd1, data: 16'h0003});
      wait_grants(2);
      tick();
      bus.req_valid = '0;
      if (grant_q.size() >= 2) begin
         check("wrap_first", 32'(grant_q[0]), 3);
         check("wrap_second", 32'(grant_q[1]), 1);
      end
      wait_drain();
      tick();

      // Reset during COMPUTE drops the request; rr_ptr restarts at 0.
      set_req(0, 2'b00, 16'hFFFF, 16'hFFFF);
      @(negedge clk);
      check("abort_grant", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = '0;
      reset = 1'b1;
      @(negedge clk);
      check("abort_in_compute", 32'(busy), 1);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("abort_resp_valid", 32'(bus.resp_valid), 0);
      check("abort_busy", 32'(busy), 0);
      repeat (4) tick();
      do_req(1, 2'b01, 16'h5000, 16'h0A0B, 16'h5A0B);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
